// File: rtl/rxd_pkg.sv
// Shared types and defaults for the rx integrate-and-dump detector.
// The optional per-lane erasure flag is built only when RXD_ERASURE_EN is defined.
package rxd_pkg;

    typedef enum logic [1:0] {
        RXD_IDLE  = 2'd0,
        RXD_ACCUM = 2'd1,
        RXD_HOLD  = 2'd2
    } rxd_state_e;

    // Defaults kept in step with the tx and channel models.
    localparam int RXD_LANES        = 12;
    localparam int RXD_SAMPLE_W     = 9;
    localparam int RXD_NUM_SAMPLES  = 8;
    localparam int RXD_THRESH       = 128;
    localparam int RXD_ERASE_MARGIN = 32;

    // A full window of maximum-valued samples must fit without wrapping.
    function automatic int rxd_acc_w(input int sample_w, input int num_samples);
        return sample_w + $clog2(num_samples + 1);
    endfunction

endpackage

// File: rtl/rxd_lane_acc.sv
// One lane of the integrate-and-dump detector: accumulator, inclusive threshold
// decision and, when RXD_ERASURE_EN is defined, the low-confidence erasure flag.
module rxd_lane_acc
    import rxd_pkg::*;
#(
    parameter int SAMPLE_W     = RXD_SAMPLE_W,
    parameter int NUM_SAMPLES  = RXD_NUM_SAMPLES,
    parameter int THRESH       = RXD_THRESH,
    parameter int ERASE_MARGIN = RXD_ERASE_MARGIN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                first,
    input  logic                accept,
    input  logic                dump,
    input  logic                clear,
    output logic                decision,
    output logic                erasure
);

    localparam int ACC_W = rxd_acc_w(SAMPLE_W, NUM_SAMPLES);
    localparam logic [ACC_W-1:0] THR = ACC_W'(NUM_SAMPLES * THRESH);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // The first sample of a window loads rather than adds, so no clear cycle is needed.
    assign sum = (first ? '0 : acc) + ACC_W'(sample);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            decision <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (accept) begin
                acc <= sum;
            end
            if (dump) begin
                decision <= (sum >= THR);
            end
        end
    end

`ifdef RXD_ERASURE_EN
    localparam logic [ACC_W-1:0] ERA_WIN = ACC_W'(NUM_SAMPLES * ERASE_MARGIN);

    logic [ACC_W-1:0] dist;

    assign dist = (sum >= THR) ? (sum - THR) : (THR - sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erasure <= 1'b0;
        end else if (dump) begin
            erasure <= (dist < ERA_WIN);
        end
    end
`else
    logic unused_margin;

    assign unused_margin = (ERASE_MARGIN != 0);
    assign erasure       = 1'b0;
`endif

endmodule

// File: rtl/rx_integrate_dump.sv
// Multi-sample soft-combining detector: integrates NUM_SAMPLES symbols per lane,
// dumps one decided word and holds it for the consumer. Optional: RXD_ERASURE_EN.
module rx_integrate_dump
    import rxd_pkg::*;
#(
    parameter int LANES        = RXD_LANES,
    parameter int SAMPLE_W     = RXD_SAMPLE_W,
    parameter int NUM_SAMPLES  = RXD_NUM_SAMPLES,
    parameter int THRESH       = RXD_THRESH,
    parameter int ERASE_MARGIN = RXD_ERASE_MARGIN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [LANES*SAMPLE_W-1:0] sample_data,
    output logic [LANES-1:0]          data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [LANES-1:0]          erasure,
    output logic                      busy
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

    localparam logic [1:0] ST_IDLE  = RXD_IDLE;
    localparam logic [1:0] ST_ACCUM = RXD_ACCUM;
    localparam logic [1:0] ST_HOLD  = RXD_HOLD;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             first;
    logic             dump;
    logic             clear;

    // Both sides transfer on a cycle where valid && ready are high at the clock edge;
    // valid never depends on ready, and data_valid stays up with stable data until taken.
    assign sample_ready = (state != ST_HOLD);
    assign accept       = sample_valid && sample_ready;
    assign first        = (state == ST_IDLE);
    assign cnt_next     = first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign dump         = accept && (cnt_next == CNT_LAST);
    assign clear        = (state == ST_HOLD) && data_ready;
    assign data_valid   = (state == ST_HOLD);
    assign busy         = (state == ST_ACCUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= cnt_next;
                        state <= dump ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (dump) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (data_ready) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rxd_lane_acc #(
            .SAMPLE_W     (SAMPLE_W),
            .NUM_SAMPLES  (NUM_SAMPLES),
            .THRESH       (THRESH),
            .ERASE_MARGIN (ERASE_MARGIN)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .sample   (sample_data[i*SAMPLE_W +: SAMPLE_W]),
            .first    (first),
            .accept   (accept),
            .dump     (dump),
            .clear    (clear),
            .decision (data_out[i]),
            .erasure  (erasure[i])
        );
    end

endmodule

// File: tb/tb_rx_integrate_dump.sv
// Directed bench for rx_integrate_dump (12 lanes, 9-bit samples, 8-sample windows).
// Erasure expectations follow RXD_ERASURE_EN when it is defined for the build.
module tb_rx_integrate_dump;

    localparam int LANES    = 12;
    localparam int SAMPLE_W = 9;

`ifdef RXD_ERASURE_EN
    localparam logic [LANES-1:0] ERA_EDGE = 12'hFFF;
`else
    localparam logic [LANES-1:0] ERA_EDGE = 12'h000;
`endif

    logic                      clk;
    logic                      reset;
    logic                      sample_valid;
    logic                      sample_ready;
    logic [LANES*SAMPLE_W-1:0] sample_data;
    logic [LANES-1:0]          data_out;
    logic                      data_valid;
    logic                      data_ready;
    logic [LANES-1:0]          erasure;
    logic                      busy;

    int n_tests = 0;
    int n_fail  = 0;

    rx_integrate_dump dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .erasure      (erasure),
        .busy         (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comparison point
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drivers: inputs change just after the falling edge, outputs are read there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_word(input logic [LANES-1:0] bits, input logic [8:0] one_v,
                              input logic [8:0] zero_v);
        for (int i = 0; i < LANES; i++) begin
            sample_data[i*SAMPLE_W +: SAMPLE_W] = bits[i] ? one_v : zero_v;
        end
    endtask

    task automatic send(input logic [LANES-1:0] bits, input logic [8:0] one_v,
                        input logic [8:0] zero_v);
        drive_word(bits, one_v, zero_v);
        sample_valid = 1'b1;
        tick();
    endtask

    task automatic handshake();
        sample_valid = 1'b0;
        data_ready   = 1'b1;
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        data_ready   = 1'b1;
        tick();
        tick();

        check("rst_valid", 16'(data_valid), 16'h0);
        check("rst_data", 16'(data_out), 16'h000);
        check("rst_erasure", 16'(erasure), 16'h000);
        check("rst_busy", 16'(busy), 16'h0);
        reset = 1'b1;
        tick();
        check("idle_ready", 16'(sample_ready), 16'h1);

        // 1: clean all-ones window, back to back
        for (int j = 0; j < 8; j++) begin
            send(12'hFFF, 9'd256, 9'd0);
            if (j == 0) check("t1_busy", 16'(busy), 16'h1);
            if (j == 6) check("t1_not_yet", 16'(data_valid), 16'h0);
        end
        check("t1_valid", 16'(data_valid), 16'h1);
        check("t1_data", 16'(data_out), 16'hFFF);
        check("t1_erasure", 16'(erasure), 16'h000);
        check("t1_hold_ready", 16'(sample_ready), 16'h0);
        check("t1_hold_busy", 16'(busy), 16'h0);
        handshake();
        check("t1_valid_drop", 16'(data_valid), 16'h0);
        check("t1_data_kept", 16'(data_out), 16'hFFF);

        // 2: noisy 0xAAA then 0x666; ones sum 2048, zeros sum 240
        for (int j = 0; j < 8; j++) send(12'hAAA, (j % 2 == 0) ? 9'd316 : 9'd196,
                                        (j % 2 == 0) ? 9'd60 : 9'd0);
        check("t2_data_aaa", 16'(data_out), 16'hAAA);
        check("t2_erasure_aaa", 16'(erasure), 16'h000);
        handshake();
        for (int j = 0; j < 8; j++) send(12'h666, (j % 2 == 0) ? 9'd196 : 9'd316,
                                        (j % 2 == 0) ? 9'd0 : 9'd60);
        check("t2_data_666", 16'(data_out), 16'h666);
        handshake();

        // 3: threshold boundary, sums 1024 and 1016
        for (int j = 0; j < 8; j++) send(12'hFFF, 9'd128, 9'd0);
        check("t3_data_128", 16'(data_out), 16'hFFF);
        check("t3_erasure_128", 16'(erasure), 16'(ERA_EDGE));
        handshake();
        for (int j = 0; j < 8; j++) send(12'hFFF, 9'd127, 9'd0);
        check("t3_data_127", 16'(data_out), 16'h000);
        check("t3_erasure_127", 16'(erasure), 16'(ERA_EDGE));
        handshake();

        // 4: backpressure with samples still offered
        data_ready = 1'b0;
        for (int j = 0; j < 8; j++) send(12'h5A5, 9'd256, 9'd0);
        check("t4_valid", 16'(data_valid), 16'h1);
        check("t4_data", 16'(data_out), 16'h5A5);
        for (int j = 0; j < 5; j++) begin
            send(12'hFFF, 9'd511, 9'd511);
            check("t4_hold_valid", 16'(data_valid), 16'h1);
            check("t4_hold_ready", 16'(sample_ready), 16'h0);
            check("t4_hold_data", 16'(data_out), 16'h5A5);
        end
        handshake();
        check("t4_valid_drop", 16'(data_valid), 16'h0);
        for (int j = 0; j < 7; j++) send(12'h000, 9'd256, 9'd0);
        check("t4_seven_no_valid", 16'(data_valid), 16'h0);
        check("t4_seven_busy", 16'(busy), 16'h1);
        send(12'h000, 9'd256, 9'd0);
        check("t4_eighth_valid", 16'(data_valid), 16'h1);
        check("t4_eighth_data", 16'(data_out), 16'h000);
        handshake();

        // 5: accept every third cycle
        for (int j = 0; j < 8; j++) begin
            send(12'hFFF, 9'd256, 9'd0);
            if (j == 7) break;
            sample_valid = 1'b0;
            sample_data  = '1;
            tick();
            tick();
            if (j == 6) check("t5_gap_no_valid", 16'(data_valid), 16'h0);
        end
        check("t5_valid", 16'(data_valid), 16'h1);
        check("t5_data", 16'(data_out), 16'hFFF);
        check("t5_erasure", 16'(erasure), 16'h000);
        handshake();

        // 6: asynchronous reset mid-window discards the partial sum
        for (int j = 0; j < 4; j++) send(12'h000, 9'd256, 9'd0);
        check("t6_busy_before", 16'(busy), 16'h1);
        sample_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_data", 16'(data_out), 16'h000);
        check("t6_async_busy", 16'(busy), 16'h0);
        check("t6_async_valid", 16'(data_valid), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int j = 0; j < 7; j++) send(12'hFFF, 9'd256, 9'd0);
        check("t6_seven_no_valid", 16'(data_valid), 16'h0);
        send(12'hFFF, 9'd256, 9'd0);
        check("t6_valid", 16'(data_valid), 16'h1);
        check("t6_data", 16'(data_out), 16'hFFF);
        handshake();

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
